// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl
//  Purpose  : Bit-serial adder controller. One full-adder cell is reused over
//             N cycles to add two N-bit operands, with a start/busy/done
//             handshake and registered sum, carry-out and signed overflow.
//  Options  : SERIAL_SUB_EN - adds a 'sub' input selecting a - b.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
`ifdef SERIAL_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   // Counter is one bit wider than strictly needed so N-1 always fits.
   localparam int            CW       = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  ra_q, rb_q, sr_q, sum_q;
   logic          carry_q, cout_q, ovf_q;
   logic [CW-1:0] cnt_q;

   logic          fa_s, fa_c;
   logic          accept;
   logic          last_bit;
   logic [N-1:0]  b_load;
   logic          carry_load;

   // The time-shared full-adder cell: x = ra[0], y = rb[0], z = carry.
   assign fa_s = ra_q[0] ^ rb_q[0] ^ carry_q;
   assign fa_c = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);

   assign accept   = (state_q == ST_IDLE) && start;
   assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

`ifdef SERIAL_SUB_EN
   // Subtraction is a + ~b + 1; cin is ignored when subtracting.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after N bits, DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

   // Operand capture, bit-serial datapath and result transfer on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra_q    <= '0;
         rb_q    <= '0;
         sr_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         ra_q    <= a;
         rb_q    <= b_load;
         carry_q <= carry_load;
         cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
         ra_q    <= {1'b0, ra_q[N-1:1]};
         rb_q    <= {1'b0, rb_q[N-1:1]};
         sr_q    <= {fa_s, sr_q[N-1:1]};
         carry_q <= fa_c;
         cnt_q   <= cnt_q + 1'b1;
         if (last_bit) begin
            // carry_q here is the carry into the MSB; fa_c is the carry out.
            sum_q  <= {fa_s, sr_q[N-1:1]};
            cout_q <= fa_c;
            ovf_q  <= carry_q ^ fa_c;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Purpose  : Directed self-checking bench for serial_adder_ctrl (N = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         cin = 1'b0;
`ifdef SERIAL_SUB_EN
   logic         sub = 1'b0;
`endif
   logic         busy, done, cout, ovf;
   logic [N-1:0] sum;

   int vectors = 0;
   int miscompares = 0;

   serial_adder_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge, then wait (bounded) for done. lat = edges from
   // the accepting edge to the edge after which done is seen.
   task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic ic, output int lat);
      a = ia; b = ib; cin = ic; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   int lat;
   int ndone;
   int t_done [3];

   initial begin
      // ---- reset ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum",  32'(sum),  32'h00);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf",  32'(ovf),  32'd0);

      // ---- 0x0F + 0x01, explicit cycle-by-cycle timing ----
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();                       // edge k
      start = 1'b0;
      check("t1_busy_k1", 32'(busy), 32'd1);
      ndone = 0;
      for (int i = 1; i < N; i++) begin
         tick();                    // edges k+1 .. k+7
         if (done) ndone++;
      end
      check("t1_no_early_done", 32'(ndone), 32'd0);
      check("t1_sum_hidden", 32'(sum), 32'h00);
      tick();                       // edge k+8
      check("t1_done",  32'(done), 32'd1);
      check("t1_busy_done", 32'(busy), 32'd1);
      check("t1_sum",   32'(sum),  32'h10);
      check("t1_cout",  32'(cout), 32'd0);
      check("t1_ovf",   32'(ovf),  32'd0);
      tick();
      check("t1_done_low", 32'(done), 32'd0);
      check("t1_busy_low", 32'(busy), 32'd0);
      check("t1_sum_held", 32'(sum),  32'h10);

      // ---- 0xFF + 0x01 ----
      do_op(8'hFF, 8'h01, 1'b0, lat);
      check("t2a_lat",  32'(lat),  32'd8);
      check("t2a_sum",  32'(sum),  32'h00);
      check("t2a_cout", 32'(cout), 32'd1);
      check("t2a_ovf",  32'(ovf),  32'd0);
      tick();

      // ---- 0x7F + 0x00 + 1 ----
      do_op(8'h7F, 8'h00, 1'b1, lat);
      check("t2b_lat",  32'(lat),  32'd8);
      check("t2b_sum",  32'(sum),  32'h80);
      check("t2b_cout", 32'(cout), 32'd0);
      check("t2b_ovf",  32'(ovf),  32'd1);
      tick();

      // ---- start while busy is ignored ----
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      tick();                       // edge k
      start = 1'b0;
      tick(); tick();               // k+1, k+2
      a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      tick();                       // k+3
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("t3_lat",  32'(lat),  32'd8);
      check("t3_sum",  32'(sum),  32'h46);
      check("t3_cout", 32'(cout), 32'd0);
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (done) ndone++;
      end
      check("t3_single_done", 32'(ndone), 32'd0);
      check("t3_idle", 32'(busy), 32'd0);

      // ---- reset mid-run ----
      a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
      tick();                       // edge k
      start = 1'b0;
      tick(); tick(); tick();       // k+1 .. k+3
      rst = 1'b1;
      tick();                       // k+4
      rst = 1'b0;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_sum",  32'(sum),  32'h00);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) ndone++;
      end
      check("t4_no_done", 32'(ndone), 32'd0);
      check("t4_sum_after", 32'(sum), 32'h00);
      do_op(8'h80, 8'h80, 1'b0, lat);
      check("t4b_lat",  32'(lat),  32'd8);
      check("t4b_sum",  32'(sum),  32'h00);
      check("t4b_cout", 32'(cout), 32'd1);
      check("t4b_ovf",  32'(ovf),  32'd1);
      tick();

      // ---- start held high: three operations, N+2 apart ----
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      ndone = 0;
      for (int t = 1; t <= 35; t++) begin
         tick();
         if (done) begin
            if (ndone < 3) t_done[ndone] = t;
            ndone++;
            check("t5_sum", 32'(sum), 32'h02);
         end
      end
      start = 1'b0;
      check("t5_count", 32'(ndone), 32'd3);
      check("t5_gap1", 32'(t_done[1] - t_done[0]), 32'd10);
      check("t5_gap2", 32'(t_done[2] - t_done[1]), 32'd10);
      for (int i = 0; i < 12; i++) tick();
      check("t5_idle", 32'(busy), 32'd0);

`ifdef SERIAL_SUB_EN
      // ---- subtraction ----
      sub = 1'b1;
      do_op(8'h05, 8'h07, 1'b0, lat);
      check("t6a_sum",  32'(sum),  32'hFE);
      check("t6a_cout", 32'(cout), 32'd0);
      check("t6a_ovf",  32'(ovf),  32'd0);
      tick();
      do_op(8'h80, 8'h01, 1'b0, lat);
      check("t6b_sum",  32'(sum),  32'h7F);
      check("t6b_cout", 32'(cout), 32'd1);
      check("t6b_ovf",  32'(ovf),  32'd1);
      sub = 1'b0;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. Time-shares a single full-adder cell (x,y,z -> c,s) across N cycles to add two N-bit operands. Handles operand capture, the bit counter, the carry flip-flop, result assembly and a start/busy/done handshake. Sits between a requesting master and the full-adder datapath and replaces an N-cell ripple chain in area-limited builds.

Parameters:
N, 8, operand/result width in bits (N >= 2)
CW, $clog2(N)+1, bit-counter width (derived; not overridden by instantiators)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  N  operand A, captured on accepted start
b  input  N  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid
sum  output  N  registered result; held until the next completion
cout  output  1  registered carry-out of bit N-1
ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (synchronous, rst=1 at the edge): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, carry flop and counter = 0. rst has priority over everything else, including mid-RUN; the partial result is discarded and no done is issued.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: if start=1 at edge k, load ra<=a, rb<=b, carry<=cin, cnt<=0, and go to RUN. busy=1 from cycle k+1.
- RUN, one bit per edge:
  - Full-adder inputs: x=ra[0], y=rb[0], z=carry.
  - Updates: carry<=c; ra and rb shift right by 1; the sum shift register shifts right with s entering at bit N-1; cnt<=cnt+1.
  - On the edge where cnt==N-1, capture the carry into bit N-1 (z) for ovf, and go to DONE.
- Transfer: on that final edge (k+N), sum<=completed shift register, cout<=c, ovf<=z^c. Internal partial sums are never visible on sum.
- DONE: done=1 for exactly one cycle (cycle after edge k+N), busy=1, then unconditional return to IDLE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+N. Back-to-back throughput is one add per N+2 cycles.
- start while busy (RUN or DONE): ignored; operands are not re-captured and in-flight state is untouched.
- start held high continuously: a new operation begins at the first IDLE edge after done.
- Changes on a, b and cin outside the accepting edge have no effect.
- Arithmetic is unsigned modulo 2^N, with cout as the (N+1)th bit. ovf interprets the operands as two's complement.
- cnt is CW bits wide so that the value N-1 is representable. cnt never wraps: it resets to 0 on every load.

Optional Feature:
SERIAL_SUB_EN
- Defined:
  - Adds port sub (input, 1), captured with the operands on an accepted start.
  - When the captured sub=1: rb is loaded with ~b and carry is loaded with 1, ignoring cin. The result is a-b modulo 2^N.
  - cout=1 means no borrow (a >= b unsigned). ovf is the signed subtraction overflow.
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only, exactly as in Behaviour.

Test Plan:
- Reset, then N=8, a=0x0F, b=0x01, cin=0, start pulsed at edge k -> busy high from k+1; done high exactly one cycle after edge k+8; sum=0x10, cout=0, ovf=0; busy low the cycle after done.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Start an add of a=0x12, b=0x34; at edge k+3 assert start with a=0xAA, b=0x55 -> the second request is ignored; sum=0x46 at done; exactly one done pulse.
- Assert rst for one cycle at edge k+4 of a run -> busy=0, done never pulses, sum=0. A following add of a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- start held high across three operations (a=1, b=1, cin=0 each time) -> three done pulses spaced N+2=10 cycles apart, each with sum=0x02.
- SERIAL_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
